// File: rtl/velocity_envelope_ctrl_if.sv
// Drum-hit trigger handshake between the trigger decoder and the envelope controller.
interface velocity_envelope_ctrl_if #(
    parameter int unsigned INST_W = 2
) ();
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [6:0]        velocity;
    logic              ready;

    modport master (output valid, output inst, output velocity, input ready);
    modport slave  (input valid, input inst, input velocity, output ready);
endinterface

// File: rtl/velocity_envelope_ctrl.sv
// Per-instrument velocity envelopes: max-hold on hits, frame snapshot to the
// visualizer, then a sequential decay sweep through one shared datapath.
module velocity_envelope_ctrl #(
    parameter int unsigned INSTRUMENT_COUNT = 3,
    parameter int unsigned DECAY_SHIFT      = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    velocity_envelope_ctrl_if.slave           trig,
    output logic [INSTRUMENT_COUNT-1:0][6:0]  inst_velocity,
    output logic                              busy,
    output logic                              bad_inst,
    output logic                              frame_overrun
);
    localparam int unsigned IW = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam logic [IW:0]   COUNT_L = (IW+1)'(INSTRUMENT_COUNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(INSTRUMENT_COUNT - 1);

    typedef enum logic {IDLE, DECAY} state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [6:0]    env [INSTRUMENT_COUNT];
    logic [6:0]    env_cur, env_hit, env_dec;
    logic [7:0]    dec_diff;
    logic          accept, inst_ok;

    assign trig.ready = (state == IDLE) && !frame_start && !rst;
    assign accept     = trig.valid && trig.ready;
    assign inst_ok    = {1'b0, trig.inst} < COUNT_L;
    assign busy       = (state == DECAY);

    // Read muxes for the decay slot and the hit target
    always_comb begin
        env_cur = '0;
        env_hit = '0;
        for (int unsigned i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (idx == IW'(i))       env_cur = env[i];
            if (trig.inst == IW'(i)) env_hit = env[i];
        end
    end

    // 8-bit subtract so the borrow from an empty envelope clamps to zero
    assign dec_diff = 8'({1'b0, env_cur}) - 8'(env_cur >> DECAY_SHIFT) - 8'd1;
    assign env_dec  = dec_diff[7] ? 7'd0 : dec_diff[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_d = DECAY;
                    idx_d   = '0;
                end
            end
            DECAY: begin
                idx_d = idx + IW'(1);
                if (idx == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < INSTRUMENT_COUNT; i++) env[i] <= '0;
            inst_velocity <= '0;
            bad_inst      <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            bad_inst      <= accept && !inst_ok;
            frame_overrun <= frame_start && (state == DECAY);
            if (state == IDLE && frame_start) begin
                for (int unsigned i = 0; i < INSTRUMENT_COUNT; i++) inst_velocity[i] <= env[i];
            end
            for (int unsigned i = 0; i < INSTRUMENT_COUNT; i++) begin
                if (state == DECAY && idx == IW'(i)) begin
                    env[i] <= env_dec;
                end else if (accept && inst_ok && trig.inst == IW'(i)) begin
                    if (trig.velocity == 7'd0)       env[i] <= 7'd0;
                    else if (trig.velocity > env_hit) env[i] <= trig.velocity;
                end
            end
        end
    end
endmodule

// File: tb/tb_velocity_envelope_ctrl.sv
// Scoreboard bench: snapshots predicted by a behavioural envelope model are
// queued at frame_start and compared when the DUT publishes them.
module tb_velocity_envelope_ctrl;
    localparam int unsigned N  = 3;
    localparam int unsigned DS = 3;

    typedef logic [N-1:0][6:0] snap_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  frame_start;
    snap_t inst_velocity;
    logic  busy, bad_inst, frame_overrun;

    velocity_envelope_ctrl_if #(.INST_W(2)) trig ();

    velocity_envelope_ctrl #(.INSTRUMENT_COUNT(N), .DECAY_SHIFT(DS)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .trig         (trig.slave),
        .inst_velocity(inst_velocity),
        .busy         (busy),
        .bad_inst     (bad_inst),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    model [N];
    snap_t sb_q [$];
    snap_t last_snap;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int decay(input int v);
        int r;
        r = v - v / (1 << DS) - 1;
        return (r < 0) ? 0 : r;
    endfunction

    task automatic hit(input int inst, input int vel);
        int n = 0;
        trig.valid    = 1'b1;
        trig.inst     = 2'(inst);
        trig.velocity = 7'(vel);
        #1;
        while (!trig.ready && n < 20) begin
            tick();
            n++;
        end
        check("hit_ready_timeout", int'(n < 20), 1);
        tick();
        trig.valid = 1'b0;
        check("bad_inst", int'(bad_inst), int'(inst >= N));
        if (inst < N) model[inst] = (vel == 0) ? 0 : ((vel > model[inst]) ? vel : model[inst]);
        tick();
        check("bad_inst_clear", int'(bad_inst), 0);
    endtask

    task automatic push_frame();
        snap_t e;
        for (int i = 0; i < N; i++) e[i] = 7'(model[i]);
        sb_q.push_back(e);
        for (int i = 0; i < N; i++) model[i] = decay(model[i]);
    endtask

    task automatic pop_compare(input string tag);
        snap_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < N; i++) check($sformatf("%s_inst%0d", tag, i), int'(inst_velocity[i]), int'(e[i]));
        last_snap = inst_velocity;
    endtask

    task automatic frame(input string tag);
        int n = 0;
        push_frame();
        frame_start = 1'b1;
        #1;
        check({tag, "_ready_low"}, int'(trig.ready), 0);
        tick();
        frame_start = 1'b0;
        pop_compare(tag);
        while (busy && n < 10) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, N);
        check({tag, "_ready_back"}, int'(trig.ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        frame_start = 1'b0;
        trig.valid = 1'b0;
        trig.inst = '0;
        trig.velocity = '0;
        for (int i = 0; i < N; i++) model[i] = 0;
        tick();
        tick();
        check("rst_ready", int'(trig.ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_bad_inst", int'(bad_inst), 0);
        check("rst_overrun", int'(frame_overrun), 0);
        check("rst_snapshot", int'(inst_velocity), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(trig.ready), 1);

        frame("empty");

        hit(1, 100);
        frame("dec1"); check("dec1_const", int'(last_snap[1]), 100);
        frame("dec2"); check("dec2_const", int'(last_snap[1]), 87);
        frame("dec3"); check("dec3_const", int'(last_snap[1]), 76);

        hit(2, 1);
        frame("min1"); check("min1_const", int'(last_snap[2]), 1);
        frame("min2"); check("min2_const", int'(last_snap[2]), 0);
        frame("min3"); check("min3_const", int'(last_snap[2]), 0);

        hit(0, 90);
        hit(0, 40);
        frame("maxhold"); check("maxhold_const", int'(last_snap[0]), 90);
        hit(0, 0);
        frame("noteoff"); check("noteoff_const", int'(last_snap[0]), 0);

        hit(3, 10);
        frame("badinst");

        // Overrun: second frame_start one cycle after the first, hit held through the sweep
        push_frame();
        frame_start   = 1'b1;
        trig.valid    = 1'b1;
        trig.inst     = 2'd0;
        trig.velocity = 7'd50;
        #1;
        check("defer_ready", int'(trig.ready), 0);
        tick();
        pop_compare("ovr");
        check("ovr_busy", int'(busy), 1);
        tick();
        frame_start = 1'b0;
        check("ovr_pulse", int'(frame_overrun), 1);
        check("ovr_snap_held", int'(inst_velocity), int'(last_snap));
        tick();
        check("ovr_pulse_clear", int'(frame_overrun), 0);
        n = 0;
        while (!trig.ready && n < 10) begin
            tick();
            n++;
        end
        check("held_hit_at_t4", n, 1);
        tick();
        trig.valid = 1'b0;
        model[0] = (50 > model[0]) ? 50 : model[0];
        check("ovr_no_bad", int'(bad_inst), 0);
        frame("after_ovr"); check("after_ovr_const", int'(last_snap[0]), 50);

        // Reset mid-sweep clears everything; next frame sweeps from scratch
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_snap", int'(inst_velocity), 0);
        for (int i = 0; i < N; i++) model[i] = 0;
        tick();
        frame("post_midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/velocity_envelope_ctrl.md
# velocity_envelope_ctrl

Per-instrument velocity envelope controller that feeds the `inst_velocity` inputs of the dry visualizer. It accepts drum-hit events through a valid/ready handshake and holds one 7-bit envelope per instrument. Once per video frame it publishes a frozen snapshot of all envelopes to the visualizer, then decays every envelope sequentially through one shared decay datapath. Sits between the trigger/MIDI decode logic and the dry shape generator, in the pixel clock domain.

## Interface
Parameters:
- `INSTRUMENT_COUNT`, 3, number of envelopes; must match the visualizer's instrument count; ≥1.
- `DECAY_SHIFT`, 3, per-frame decay is `(v >> DECAY_SHIFT) + 1`; range 1..6.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  single-cycle pulse, issued once per frame outside active draw.
- `trig_valid`  in  1  hit event valid.
- `trig_inst`  in  `$clog2(INSTRUMENT_COUNT)` (min 1)  instrument index of the hit.
- `trig_velocity`  in  7  hit velocity; 0 means note-off.
- `trig_ready`  out  1  controller can accept a hit this cycle.
- `inst_velocity[INSTRUMENT_COUNT-1:0]`  out  7 each  frame snapshot of the envelopes; drives the visualizer.
- `busy`  out  1  high while the decay sweep runs.
- `bad_inst`  out  1  one-cycle pulse: an accepted hit had `trig_inst ≥ INSTRUMENT_COUNT`.
- `frame_overrun`  out  1  one-cycle pulse: `frame_start` arrived while `busy`.

## Operation
- Internal state: `env[i]` (7 bits each) and an FSM with states `IDLE` and `DECAY`, plus index `idx`.
- `trig_ready = (state == IDLE) && !frame_start`. This is combinational from state and `frame_start`. A handshake completes when `trig_valid && trig_ready`.
- Accepted hit, valid instrument:
  - If `trig_velocity == 0`, `env[trig_inst] <= 0`.
  - Otherwise `env[trig_inst] <= max(env[trig_inst], trig_velocity)`. A softer retrigger never cuts a louder decaying hit.
- Accepted hit with `trig_inst ≥ INSTRUMENT_COUNT`:
  - The handshake completes and the hit is dropped.
  - `bad_inst` pulses on the next cycle.
  - No `env` changes.
- `IDLE` with `frame_start`, on that edge:
  - `inst_velocity[i] <= env[i]` for all i. This is the snapshot, taken before decay.
  - `idx <= 0`, state becomes `DECAY`.
- `DECAY`, one instrument per cycle:
  - `env[idx] <= sat0(env[idx] − (env[idx] >> DECAY_SHIFT) − 1)`. The subtraction is computed in 8 bits and clamped at 0, so an `env` of 0 stays 0.
  - `idx` increments. After `idx == INSTRUMENT_COUNT−1` is processed, state returns to `IDLE`.
- `frame_start` while in `DECAY`:
  - Ignored: no snapshot and no restart.
  - `frame_overrun` pulses on the next cycle.
- `trig_valid` while not ready: no effect. The requester must hold the event until the handshake completes.
- `inst_velocity` changes only on the snapshot edge. It is stable for the entire frame.

## Timing
- Reset, with `rst` sampled high:
  - All `env`, `inst_velocity`, `idx`: 0.
  - State: `IDLE`.
  - `busy`, `bad_inst`, `frame_overrun`: 0.
  - `trig_ready` is 0 during the reset cycle and 1 on the first cycle after reset (absent `frame_start`).
- Reset mid-sweep aborts the sweep. The next `frame_start` starts a fresh sweep from `idx` 0.
- Hit accepted at edge T: `env` updated at T+1. It becomes visible on `inst_velocity` only after the next snapshot.
- `frame_start` high in cycle T:
  - `inst_velocity` is new from T+1.
  - `busy` is high for cycles T+1 .. T+INSTRUMENT_COUNT.
  - `trig_ready` is low for cycles T .. T+INSTRUMENT_COUNT and high again at T+INSTRUMENT_COUNT+1.
- Same cycle `frame_start` and `trig_valid` in `IDLE`: the frame wins, `trig_ready` = 0 and the hit is deferred.
- Hit accepted in the last `IDLE` cycle before `frame_start`: it is included in that frame's snapshot.
- Worst-case hit-to-display latency is one frame plus one cycle.

## Test plan
- Reset, then `frame_start` → all `inst_velocity` = 0; `busy` high for exactly 3 cycles; `trig_ready` returns on cycle T+4.
- Hit inst 1 vel 100, then 3 frames (`DECAY_SHIFT` = 3) → snapshots read 100, 87, 76. Inst 0 and inst 2 stay 0.
- Hit inst 2 vel 1, then 2 frames → snapshots read 1, then 0. Further frames stay 0 with no underflow wrap.
- Hit inst 0 vel 90, then inst 0 vel 40 before the next frame → snapshot reads 90. A following vel-0 hit → next snapshot reads 0.
- Hit with `trig_inst` = 3 (`INSTRUMENT_COUNT` = 3) → handshake completes, `bad_inst` pulses once, all snapshots unchanged.
- `frame_start` pulsed again 1 cycle after the first → `frame_overrun` pulses once, and the snapshot taken by the first pulse is unchanged. A `trig_valid` held through the sweep is accepted at T+4.
